usensor_scheduler: RTL
======================

// Module: usensor_scheduler
// PURPOSE
// - Round-robin sequencer sharing one ranging time-slot among NUM_SENSORS HC-SR04-style sensors.
// - Only one sensor is pinged at a time, so one sensor cannot hear another's echo.
// - Per ping: issues the trigger, times the echo, converts it to cm, then waits a holdoff before the next sensor.
// - Sits between the GPIO pins and the paddle logic, replacing free-running per-sensor ranging.
// PARAMETERS
// - NUM_SENSORS     2          sensors served, index 0..N-1
// - TRIG_CYCLES     500        trig high time (10 us @ 50 MHz)
// - CYCLES_PER_CM   2900       echo-high clocks per reported cm
// - TIMEOUT_CYCLES  1500000    max wait for echo rise, and max echo-high time (30 ms)
// - HOLDOFF_CYCLES  3000000    quiet time after each ping before the next sensor (60 ms)
// - DIST_W          9          distance width in cm
// - DIST_OFFSET     2          constant added to the measured cm (sensor calibration)
// PORTS
// - clock         in   1                  system clock (CLOCK_50)
// - reset         in   1                  asynchronous, active-high reset
// - enable        in   1                  1 = keep scheduling pings
// - echo          in   NUM_SENSORS        raw echo pins, asynchronous to clock
// - trig          out  NUM_SENSORS        trigger pins, one-hot or zero
// - distance      out  NUM_SENSORS*DIST_W packed; sensor i at [i*DIST_W +: DIST_W]
// - dist_valid    out  NUM_SENSORS        1-cycle strobe when sensor i's distance updates
// - timeout       out  NUM_SENSORS        level; 1 = last ping of sensor i timed out
// - cur_sensor    out  $clog2(NUM_SENSORS) index of the sensor owning the slot
// - busy          out  1                  1 whenever state != IDLE
// BEHAVIOUR
// - Reset values:
//   - All outputs are 0: trig, distance, dist_valid, timeout, cur_sensor, busy.
//   - Reset acts immediately, so trig drops asynchronously.
// - Echo synchronizer:
//   - Each echo bit passes through a 2-flop synchronizer.
//   - The FSM sees only the synced echo of cur_sensor, so everything below is +2 cycles vs the pin.
// - FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
//   - IDLE: if enable=1, load cyc_cnt=0 and go to TRIG next cycle.
//   - TRIG:
//     - trig[cur_sensor]=1 for exactly TRIG_CYCLES clocks, then 0 and go to WAIT_RISE.
//     - Echo activity during TRIG is ignored.
//   - WAIT_RISE:
//     - On echo=1: go to MEASURE with cyc_cnt=0, cm_cnt=0.
//     - If TIMEOUT_CYCLES clocks pass with no rise: timeout event.
//   - MEASURE, each echo-high clock:
//     - The prescaler increments.
//     - When the prescaler reaches CYCLES_PER_CM-1, it wraps to 0 and cm_cnt increments.
//     - cm_cnt saturates at its maximum.
//   - MEASURE, echo falls:
//     - distance[cur] <= sat(cm_cnt + DIST_OFFSET), saturating at 2^DIST_W-1.
//     - timeout[cur] <= 0.
//     - dist_valid[cur] pulses for 1 cycle, the cycle after the falling edge is seen.
//     - Go to HOLDOFF.
//   - MEASURE, echo still high after TIMEOUT_CYCLES: timeout event.
//   - Timeout event:
//     - distance[cur] <= all-ones, timeout[cur] <= 1, dist_valid[cur] pulses.
//     - Go to HOLDOFF.
//   - HOLDOFF:
//     - Wait HOLDOFF_CYCLES clocks.
//     - Then cur_sensor <= (cur_sensor == N-1) ? 0 : cur_sensor+1 (wrap-around).
//     - Go to TRIG if enable=1, otherwise go to IDLE.
// - enable is sampled only in IDLE and at the end of HOLDOFF.
//   - Deasserting it mid-ping completes the current ping and holdoff; no ping is aborted.
// - Reset mid-ping: the measurement is discarded and the next ping after release is sensor 0.
// - A sensor's distance and timeout hold between its own updates.
// - Other sensors' outputs never change during a ping.
// - A single cyc_cnt is shared by TRIG, WAIT_RISE, MEASURE and HOLDOFF.
//   - Its width is wide enough for max(TIMEOUT_CYCLES, HOLDOFF_CYCLES).
// STRUCTURE
// - Shared package (usensor_pkg):
//   - FSM state encoding.
//   - Default timing constants at 50 MHz.
//   - DIST_W and the all-ones TIMEOUT_DIST constant.
// - Sub-module: usensor_echo_timer.
//   - Contains the prescaler and cm_cnt.
//   - Inputs: clear, count_en. Output: cm_cnt.
// - The FSM, synchronizers and output registers live in the top.
// TESTING (bench parameters: N=2, TRIG=4, CPCM=10, TIMEOUT=200, HOLDOFF=50, DIST_W=9, OFFSET=2)
// - Reset, enable=1:
//   - trig[0] is high for exactly 4 cycles, then 0.
//   - trig[1] stays 0.
//   - busy=1.
// - Sensor 0 echo high for 100 cycles:
//   - distance[0]=12 and dist_valid[0] pulses once for 1 cycle.
//   - timeout[0]=0.
// - No echo rise on sensor 1:
//   - 200 cycles after trig falls, distance[1]=511 and timeout[1]=1.
//   - dist_valid[1] pulses.
//   - distance[0] is unchanged.
// - Echo stuck high on sensor 0 for 300 cycles: timeout[0]=1 and distance[0]=511.
//   - A later 55-cycle echo on sensor 0 gives distance[0]=7 and clears timeout[0].
// - Round robin: cur_sensor goes 0,1,0,1.
//   - trig is never set while busy is in HOLDOFF.
//   - trig is never two-hot.
// - Reset asserted during MEASURE: trig=0 at once and all outputs are 0.
//   - After release, the first trig is on sensor 0.
// - enable dropped in TRIG: the ping completes, then the FSM returns to IDLE with busy=0 and no further trig.

Source files
------------

// File: rtl/usensor_pkg.sv
// ---------------------------------------------------------------------------
// usensor_pkg
// Shared definitions for the ultrasonic ranging scheduler:
//   - state_t       : scheduler FSM state encoding
//   - DEF_*         : default timing constants for a 50 MHz clock
//   - DIST_W_DEF    : default distance width in cm
//   - TIMEOUT_DIST  : all-ones distance reported when a ping times out
// ---------------------------------------------------------------------------
package usensor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRIG,
      ST_WAIT_RISE,
      ST_MEASURE,
      ST_HOLDOFF
   } state_t;

   // Defaults for a 50 MHz system clock.
   localparam int DEF_NUM_SENSORS    = 2;
   localparam int DEF_TRIG_CYCLES    = 500;       // 10 us trigger pulse
   localparam int DEF_CYCLES_PER_CM  = 2900;      // echo-high clocks per cm
   localparam int DEF_TIMEOUT_CYCLES = 1500000;   // 30 ms
   localparam int DEF_HOLDOFF_CYCLES = 3000000;   // 60 ms
   localparam int DEF_DIST_OFFSET    = 2;         // sensor calibration, cm

   localparam int DIST_W_DEF = 9;
   localparam logic [DIST_W_DEF-1:0] TIMEOUT_DIST = '1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/usensor_echo_timer.sv
// ---------------------------------------------------------------------------
// usensor_echo_timer
// Converts echo-high clock cycles into centimetres.  A prescaler counts
// CYCLES_PER_CM clocks per cm; cm_cnt saturates at all-ones.
// Ports:
//   clock    in   system clock
//   reset    in   asynchronous active-high reset
//   clear    in   synchronous clear of prescaler and cm_cnt (wins over count)
//   count_en in   one echo-high clock to accumulate
//   cm_cnt   out  whole centimetres measured so far
// ---------------------------------------------------------------------------
module usensor_echo_timer
   import usensor_pkg::*;
#(
   parameter int CYCLES_PER_CM = DEF_CYCLES_PER_CM,
   parameter int DIST_W        = DIST_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              count_en,
   output logic [DIST_W-1:0] cm_cnt
);

   localparam int PS_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

   logic [PS_W-1:0] prescaler;

   // NOTE: sequential state uses non-blocking <= so every flop samples the
   // values from before the clock edge, independent of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prescaler <= '0;
         cm_cnt    <= '0;
      end else if (clear) begin
         prescaler <= '0;
         cm_cnt    <= '0;
      end else if (count_en) begin
         if (prescaler == PS_W'(CYCLES_PER_CM - 1)) begin
            prescaler <= '0;
            if (cm_cnt != '1) begin
               cm_cnt <= cm_cnt + DIST_W'(1);
            end
         end else begin
            prescaler <= prescaler + PS_W'(1);
         end
      end
   end

endmodule

// File: rtl/usensor_scheduler.sv
// ---------------------------------------------------------------------------
// usensor_scheduler
// Round-robin sequencer sharing one ranging slot among NUM_SENSORS
// HC-SR04-style sensors: trigger one sensor, time its echo, convert to cm,
// wait a holdoff, then move to the next sensor.
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous active-high reset
//   enable      in   1 = keep scheduling pings (sampled in IDLE / end of holdoff)
//   echo        in   raw echo pins, asynchronous to clock
//   trig        out  trigger pins, one-hot or zero
//   distance    out  packed distances, sensor i at [i*DIST_W +: DIST_W]
//   dist_valid  out  1-cycle strobe when sensor i's distance updates
//   timeout     out  1 = last ping of sensor i timed out
//   cur_sensor  out  index of the sensor owning the slot
//   busy        out  1 whenever the FSM is not idle
// ---------------------------------------------------------------------------
module usensor_scheduler
   import usensor_pkg::*;
#(
   parameter int NUM_SENSORS    = DEF_NUM_SENSORS,
   parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
   parameter int CYCLES_PER_CM  = DEF_CYCLES_PER_CM,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
   parameter int DIST_W         = DIST_W_DEF,
   parameter int DIST_OFFSET    = DEF_DIST_OFFSET,
   localparam int SEL_W         = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [NUM_SENSORS-1:0]        echo,
   output logic [NUM_SENSORS-1:0]        trig,
   output logic [NUM_SENSORS*DIST_W-1:0] distance,
   output logic [NUM_SENSORS-1:0]        dist_valid,
   output logic [NUM_SENSORS-1:0]        timeout,
   output logic [SEL_W-1:0]              cur_sensor,
   output logic                          busy
);

   // One counter serves every timed state, so size it for the longest.
   localparam int CNT_MAX = max3(TRIG_CYCLES, TIMEOUT_CYCLES, HOLDOFF_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t                   state;
   logic [CNT_W-1:0]         cyc_cnt;
   logic [NUM_SENSORS-1:0]   echo_meta;
   logic [NUM_SENSORS-1:0]   echo_sync;
   logic                     echo_cur;
   logic                     timer_clear;
   logic                     timer_en;
   logic [DIST_W-1:0]        cm_cnt;
   logic [DIST_W:0]          cm_sum;
   logic [DIST_W-1:0]        cm_dist;
   logic [SEL_W-1:0]         next_sensor;

   function automatic logic [NUM_SENSORS-1:0] sel_mask(input logic [SEL_W-1:0] idx);
      return NUM_SENSORS'(1) << idx;
   endfunction

   // Two-flop synchronizer on every echo pin.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         echo_meta <= '0;
         echo_sync <= '0;
      end else begin
         echo_meta <= echo;
         echo_sync <= echo_meta;
      end
   end

   assign echo_cur    = echo_sync[cur_sensor];
   assign next_sensor = (cur_sensor == SEL_W'(NUM_SENSORS - 1)) ? '0
                                                                : cur_sensor + SEL_W'(1);

   // The rise cycle seen in WAIT_RISE is already an echo-high clock, so it
   // is counted; everywhere outside a measurement the timer is held clear,
   // which also ignores any echo activity during TRIG.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the
      // case leaves it unassigned, which would infer a latch.
      timer_clear = 1'b1;
      timer_en    = 1'b0;
      case (state)
         ST_WAIT_RISE: begin
            if (echo_cur) begin
               timer_clear = 1'b0;
               timer_en    = 1'b1;
            end
         end
         ST_MEASURE: begin
            timer_clear = 1'b0;
            timer_en    = echo_cur;
         end
         default: ;
      endcase
   end

   // Calibrated distance, saturating at all-ones.
   always_comb begin
      cm_sum  = {1'b0, cm_cnt} + (DIST_W + 1)'(DIST_OFFSET);
      cm_dist = cm_sum[DIST_W] ? '1 : cm_sum[DIST_W-1:0];
   end

   usensor_echo_timer #(
      .CYCLES_PER_CM (CYCLES_PER_CM),
      .DIST_W        (DIST_W)
   ) u_echo_timer (
      .clock    (clock),
      .reset    (reset),
      .clear    (timer_clear),
      .count_en (timer_en),
      .cm_cnt   (cm_cnt)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         cyc_cnt    <= '0;
         trig       <= '0;
         distance   <= '0;
         dist_valid <= '0;
         timeout    <= '0;
         cur_sensor <= '0;
         busy       <= 1'b0;
      end else begin
         dist_valid <= '0;
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  state   <= ST_TRIG;
                  cyc_cnt <= '0;
                  trig    <= sel_mask(cur_sensor);
                  busy    <= 1'b1;
               end
            end

            ST_TRIG: begin
               if (cyc_cnt == CNT_W'(TRIG_CYCLES - 1)) begin
                  trig    <= '0;
                  state   <= ST_WAIT_RISE;
                  cyc_cnt <= '0;
               end else begin
                  cyc_cnt <= cyc_cnt + CNT_W'(1);
               end
            end

            ST_WAIT_RISE: begin
               if (echo_cur) begin
                  state   <= ST_MEASURE;
                  cyc_cnt <= '0;
               end else if (cyc_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  distance[cur_sensor*DIST_W +: DIST_W] <= '1;
                  timeout[cur_sensor]                   <= 1'b1;
                  dist_valid[cur_sensor]                <= 1'b1;
                  state                                 <= ST_HOLDOFF;
                  cyc_cnt                               <= '0;
               end else begin
                  cyc_cnt <= cyc_cnt + CNT_W'(1);
               end
            end

            ST_MEASURE: begin
               if (!echo_cur) begin
                  distance[cur_sensor*DIST_W +: DIST_W] <= cm_dist;
                  timeout[cur_sensor]                   <= 1'b0;
                  dist_valid[cur_sensor]                <= 1'b1;
                  state                                 <= ST_HOLDOFF;
                  cyc_cnt                               <= '0;
               end else if (cyc_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  distance[cur_sensor*DIST_W +: DIST_W] <= '1;
                  timeout[cur_sensor]                   <= 1'b1;
                  dist_valid[cur_sensor]                <= 1'b1;
                  state                                 <= ST_HOLDOFF;
                  cyc_cnt                               <= '0;
               end else begin
                  cyc_cnt <= cyc_cnt + CNT_W'(1);
               end
            end

            ST_HOLDOFF: begin
               if (cyc_cnt == CNT_W'(HOLDOFF_CYCLES - 1)) begin
                  cur_sensor <= next_sensor;
                  cyc_cnt    <= '0;
                  if (enable) begin
                     state <= ST_TRIG;
                     trig  <= sel_mask(next_sensor);
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + CNT_W'(1);
               end
            end

            default: begin
               state <= ST_IDLE;
               trig  <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
